// File: rtl/sbp_lookup_sched.sv
// Merges lookup requests and queued table updates onto the lookup engine's
// single input slot; lookups win, but a burst limit forces pending updates through.
module sbp_lookup_sched #(
  parameter int STAGE_ID_BITS    = 6,
  parameter int LOCATION_BITS    = 11,
  parameter int UPD_FIFO_DEPTH   = 16,
  parameter int MAX_LOOKUP_BURST = 8,
  parameter int PIPE_LATENCY     = 34
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                lk_valid_i,
  output logic                                lk_ready_o,
  input  logic [31:0]                         lk_ip_addr_i,
  input  logic                                upd_valid_i,
  output logic                                upd_ready_o,
  input  logic [STAGE_ID_BITS-1:0]            upd_stage_id_i,
  input  logic [LOCATION_BITS-1:0]            upd_location_i,
  input  logic [31:0]                         upd_ip_addr_i,
  input  logic [5:0]                          upd_length_i,
  input  logic [STAGE_ID_BITS-1:0]            upd_childs_stage_id_i,
  input  logic [LOCATION_BITS-1:0]            upd_childs_location_i,
  input  logic [1:0]                          upd_childs_lr_i,
  output logic                                lookup_o,
  output logic [31:0]                         ip_addr_o,
  output logic                                upd_o,
  output logic [STAGE_ID_BITS-1:0]            upd_stage_id_o,
  output logic [LOCATION_BITS-1:0]            upd_location_o,
  output logic [31:0]                         upd_ip_addr_o,
  output logic [5:0]                          upd_length_o,
  output logic [STAGE_ID_BITS-1:0]            upd_childs_stage_id_o,
  output logic [LOCATION_BITS-1:0]            upd_childs_location_o,
  output logic [1:0]                          upd_childs_lr_o,
  output logic [$clog2(UPD_FIFO_DEPTH):0]     upd_count_o,
  output logic                                upd_idle_o
);

  localparam int PTR_W   = $clog2(UPD_FIFO_DEPTH);
  localparam int CNT_W   = $clog2(UPD_FIFO_DEPTH) + 1;
  localparam int BURST_W = (MAX_LOOKUP_BURST > 0) ? $clog2(MAX_LOOKUP_BURST + 1) : 1;
  localparam int INFL_W  = (PIPE_LATENCY > 0) ? $clog2(PIPE_LATENCY + 1) : 1;

  localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(UPD_FIFO_DEPTH);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_LOOKUP_BURST);
  localparam logic [INFL_W-1:0]  INFL_LOAD = INFL_W'(PIPE_LATENCY);

  typedef struct packed {
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic [31:0]              ip_addr;
    logic [5:0]               length;
    logic [STAGE_ID_BITS-1:0] childs_stage_id;
    logic [LOCATION_BITS-1:0] childs_location;
    logic [1:0]               childs_lr;
  } upd_entry_t;

  upd_entry_t fifo_mem [UPD_FIFO_DEPTH];

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_nxt;
  logic [INFL_W-1:0]  inflight_cnt;
  logic [INFL_W-1:0]  inflight_nxt;
  logic               idle_nxt;

  logic               fifo_nonempty;
  logic               force_upd;
  logic               push;
  logic               lk_issue;
  logic               upd_issue;
  upd_entry_t         wr_entry;
  upd_entry_t         head_entry;

  logic               lk_vld_p1;
  logic               upd_vld_p1;
  logic [31:0]        ip_addr_p1;
  upd_entry_t         upd_data_p1;
  logic               idle_p1;

  assign fifo_nonempty = (count != '0);
  // Burst counter saturates at the limit, so equality is the "limit reached" test.
  assign force_upd     = fifo_nonempty && (burst_cnt == BURST_MAX);
  assign lk_ready_o    = rst && !force_upd;
  assign upd_ready_o   = rst && (count < DEPTH_C);

  assign push      = upd_valid_i && upd_ready_o;
  assign lk_issue  = lk_valid_i && lk_ready_o;
  assign upd_issue = !lk_issue && fifo_nonempty;

  assign wr_entry = '{
    stage_id:        upd_stage_id_i,
    location:        upd_location_i,
    ip_addr:         upd_ip_addr_i,
    length:          upd_length_i,
    childs_stage_id: upd_childs_stage_id_i,
    childs_location: upd_childs_location_i,
    childs_lr:       upd_childs_lr_i
  };
  assign head_entry = fifo_mem[rd_ptr];

  always_comb begin
    count_nxt    = count;
    burst_nxt    = burst_cnt;
    inflight_nxt = inflight_cnt;

    if (push && !upd_issue) begin
      count_nxt = count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!push && upd_issue) begin
      count_nxt = count - {{(CNT_W-1){1'b0}}, 1'b1};
    end

    if (upd_issue || !fifo_nonempty) begin
      burst_nxt = '0;
    end else if (lk_issue && (burst_cnt != BURST_MAX)) begin
      burst_nxt = burst_cnt + {{(BURST_W-1){1'b0}}, 1'b1};
    end

    if (upd_issue) begin
      inflight_nxt = INFL_LOAD;
    end else if (inflight_cnt != '0) begin
      inflight_nxt = inflight_cnt - {{(INFL_W-1){1'b0}}, 1'b1};
    end

    idle_nxt = (count_nxt == '0) && (inflight_nxt == '0);
  end

  // Storage is data-only; occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      burst_cnt    <= '0;
      inflight_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (upd_issue) begin
        rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      count        <= count_nxt;
      burst_cnt    <= burst_nxt;
      inflight_cnt <= inflight_nxt;
    end
  end

  // Stage p1: registered engine slot, exactly one of lookup/update or neither.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lk_vld_p1   <= 1'b0;
      upd_vld_p1  <= 1'b0;
      ip_addr_p1  <= '0;
      upd_data_p1 <= '0;
      idle_p1     <= 1'b1;
    end else begin
      lk_vld_p1   <= lk_issue;
      upd_vld_p1  <= upd_issue;
      ip_addr_p1  <= lk_issue ? lk_ip_addr_i : 32'd0;
      upd_data_p1 <= upd_issue ? head_entry : '0;
      idle_p1     <= idle_nxt;
    end
  end

  assign lookup_o              = lk_vld_p1;
  assign upd_o                 = upd_vld_p1;
  assign ip_addr_o             = ip_addr_p1;
  assign upd_stage_id_o        = upd_data_p1.stage_id;
  assign upd_location_o        = upd_data_p1.location;
  assign upd_ip_addr_o         = upd_data_p1.ip_addr;
  assign upd_length_o          = upd_data_p1.length;
  assign upd_childs_stage_id_o = upd_data_p1.childs_stage_id;
  assign upd_childs_location_o = upd_data_p1.childs_location;
  assign upd_childs_lr_o       = upd_data_p1.childs_lr;
  assign upd_count_o           = count;
  assign upd_idle_o            = idle_p1;

endmodule

// File: tb/tb_sbp_lookup_sched.sv
// Directed bench for sbp_lookup_sched: one instance with burst limit 8,
// one with burst limit 0 (pending updates always win).
module tb_sbp_lookup_sched;

  localparam int SB = 6;
  localparam int LB = 11;
  localparam int EW = 74;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          lk_valid, upd_valid, lk_valid0, upd_valid0;
  logic [31:0]   lk_ip_addr;
  logic [SB-1:0] upd_stage_id, upd_childs_stage_id;
  logic [LB-1:0] upd_location, upd_childs_location;
  logic [31:0]   upd_ip_addr;
  logic [5:0]    upd_length;
  logic [1:0]    upd_childs_lr;

  logic          lk_ready, upd_ready, lookup, upd, idle;
  logic [31:0]   ip_addr_out;
  logic [SB-1:0] o_stage, o_cstage;
  logic [LB-1:0] o_loc, o_cloc;
  logic [31:0]   o_ip;
  logic [5:0]    o_len;
  logic [1:0]    o_lr;
  logic [4:0]    count;

  logic          lk_ready0, upd_ready0, lookup0, upd0, idle0;
  logic [31:0]   ip_addr_out0;
  logic [SB-1:0] o_stage0, o_cstage0;
  logic [LB-1:0] o_loc0, o_cloc0;
  logic [31:0]   o_ip0;
  logic [5:0]    o_len0;
  logic [1:0]    o_lr0;
  logic [4:0]    count0;

  sbp_lookup_sched #(.MAX_LOOKUP_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .lk_valid_i(lk_valid), .lk_ready_o(lk_ready), .lk_ip_addr_i(lk_ip_addr),
    .upd_valid_i(upd_valid), .upd_ready_o(upd_ready),
    .upd_stage_id_i(upd_stage_id), .upd_location_i(upd_location),
    .upd_ip_addr_i(upd_ip_addr), .upd_length_i(upd_length),
    .upd_childs_stage_id_i(upd_childs_stage_id), .upd_childs_location_i(upd_childs_location),
    .upd_childs_lr_i(upd_childs_lr),
    .lookup_o(lookup), .ip_addr_o(ip_addr_out), .upd_o(upd),
    .upd_stage_id_o(o_stage), .upd_location_o(o_loc), .upd_ip_addr_o(o_ip),
    .upd_length_o(o_len), .upd_childs_stage_id_o(o_cstage),
    .upd_childs_location_o(o_cloc), .upd_childs_lr_o(o_lr),
    .upd_count_o(count), .upd_idle_o(idle)
  );

  sbp_lookup_sched #(.MAX_LOOKUP_BURST(0)) dut0 (
    .clk(clk), .rst(rst),
    .lk_valid_i(lk_valid0), .lk_ready_o(lk_ready0), .lk_ip_addr_i(lk_ip_addr),
    .upd_valid_i(upd_valid0), .upd_ready_o(upd_ready0),
    .upd_stage_id_i(upd_stage_id), .upd_location_i(upd_location),
    .upd_ip_addr_i(upd_ip_addr), .upd_length_i(upd_length),
    .upd_childs_stage_id_i(upd_childs_stage_id), .upd_childs_location_i(upd_childs_location),
    .upd_childs_lr_i(upd_childs_lr),
    .lookup_o(lookup0), .ip_addr_o(ip_addr_out0), .upd_o(upd0),
    .upd_stage_id_o(o_stage0), .upd_location_o(o_loc0), .upd_ip_addr_o(o_ip0),
    .upd_length_o(o_len0), .upd_childs_stage_id_o(o_cstage0),
    .upd_childs_location_o(o_cloc0), .upd_childs_lr_o(o_lr0),
    .upd_count_o(count0), .upd_idle_o(idle0)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_entry(input int n);
    return {6'(n), 11'(n * 7), 32'hC0A80000 + 32'(n), 6'(n % 33), 6'(~n), 11'(n * 3 + 1), 2'(n)};
  endfunction

  task automatic set_upd(input logic [EW-1:0] e);
    {upd_stage_id, upd_location, upd_ip_addr, upd_length,
     upd_childs_stage_id, upd_childs_location, upd_childs_lr} = e;
  endtask

  function automatic logic [EW-1:0] out_entry();
    return {o_stage, o_loc, o_ip, o_len, o_cstage, o_cloc, o_lr};
  endfunction

  function automatic logic [EW-1:0] out_entry0();
    return {o_stage0, o_loc0, o_ip0, o_len0, o_cstage0, o_cloc0, o_lr0};
  endfunction

  task automatic idle_inputs();
    lk_valid = 1'b0; upd_valid = 1'b0; lk_valid0 = 1'b0; upd_valid0 = 1'b0;
    lk_ip_addr = 32'd0;
    set_upd('0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic          lk;
    logic [31:0]   addr;
    logic          uv;
    logic [EW-1:0] ue;
    logic          e_lk;
    logic [31:0]   e_ip;
    logic          e_upd;
    logic [EW-1:0] e_ue;
    logic [4:0]    e_cnt;
  } vec_t;

  vec_t vecs[9];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [EW-1:0] e1, e2, e3, e_single, e_b, e;
    int k, n, stale, c;
    logic found, full_checked, pop_at_full, done;

    e1 = mk_entry(1);
    e2 = mk_entry(2);
    e3 = mk_entry(3);
    vecs[0] = '{1'b1, 32'h11111111, 1'b0, '0, 1'b1, 32'h11111111, 1'b0, '0, 5'd0};
    vecs[1] = '{1'b0, 32'h0,        1'b1, e1, 1'b0, 32'h0,        1'b0, '0, 5'd1};
    vecs[2] = '{1'b1, 32'h22222222, 1'b1, e2, 1'b1, 32'h22222222, 1'b0, '0, 5'd2};
    vecs[3] = '{1'b0, 32'h0,        1'b0, '0, 1'b0, 32'h0,        1'b1, e1, 5'd1};
    vecs[4] = '{1'b0, 32'h0,        1'b1, e3, 1'b0, 32'h0,        1'b1, e2, 5'd1};
    vecs[5] = '{1'b0, 32'h0,        1'b0, '0, 1'b0, 32'h0,        1'b1, e3, 5'd0};
    vecs[6] = '{1'b0, 32'h0,        1'b0, '0, 1'b0, 32'h0,        1'b0, '0, 5'd0};
    vecs[7] = '{1'b1, 32'hFFFFFFFF, 1'b0, '0, 1'b1, 32'hFFFFFFFF, 1'b0, '0, 5'd0};
    vecs[8] = '{1'b0, 32'h0,        1'b0, '0, 1'b0, 32'h0,        1'b0, '0, 5'd0};

    // Reset state
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_lookup", lookup, 0);
    check("rst_upd", upd, 0);
    check("rst_idle", idle, 1);
    check("rst_count", count, 0);
    check("rst_lk_ready_low", lk_ready, 0);
    check("rst_upd_ready_low", upd_ready, 0);
    check("rst_idle0", idle0, 1);
    rst = 1'b1;
    #1;
    check("post_rst_lk_ready", lk_ready, 1);
    check("post_rst_upd_ready", upd_ready, 1);
    @(negedge clk);
    check("idle_strobes", {lookup, upd}, 0);
    check("idle_idle", idle, 1);

    // Single update, no lookups
    e_single = {6'd3, 11'd5, 32'h0A000000, 6'd8, 6'd0, 11'd0, 2'd0};
    set_upd(e_single);
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    check("single_no_fallthrough", upd, 0);
    check("single_count", count, 1);
    check("single_idle_fall", idle, 0);
    @(negedge clk);
    check("single_upd", upd, 1);
    check("single_lookup", lookup, 0);
    check("single_fields", out_entry(), e_single);
    found = 1'b0;
    k = 0;
    while (!found && k < 40) begin
      @(negedge clk);
      k++;
      if (idle) found = 1'b1;
    end
    check("single_idle_latency", k, 34);

    // Table-driven single-cycle vectors
    do_reset();
    for (int i = 0; i < 9; i++) begin
      lk_valid   = vecs[i].lk;
      lk_ip_addr = vecs[i].addr;
      upd_valid  = vecs[i].uv;
      set_upd(vecs[i].ue);
      @(negedge clk);
      check($sformatf("vec%0d_lookup", i), lookup, vecs[i].e_lk);
      check($sformatf("vec%0d_ip", i), ip_addr_out, vecs[i].e_ip);
      check($sformatf("vec%0d_upd", i), upd, vecs[i].e_upd);
      check($sformatf("vec%0d_fields", i), out_entry(), vecs[i].e_ue);
      check($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
    end
    idle_inputs();

    // Burst limit 8 with one queued update
    do_reset();
    e_b = mk_entry(40);
    set_upd(e_b);
    upd_valid  = 1'b1;
    lk_ip_addr = 32'hAB000000;
    @(negedge clk);
    upd_valid = 1'b0;
    lk_valid  = 1'b1;
    check("burst_queued", count, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("burst_lk%0d_strobes", i), {lookup, upd}, 2'b10);
      check($sformatf("burst_lk%0d_ready", i), lk_ready, (i == 7) ? 1'b0 : 1'b1);
    end
    check("burst_ip", ip_addr_out, 32'hAB000000);
    @(negedge clk);
    check("burst_upd_strobes", {lookup, upd}, 2'b01);
    check("burst_upd_fields", out_entry(), e_b);
    check("burst_ready_back", lk_ready, 1);
    @(negedge clk);
    check("burst_resume", {lookup, upd}, 2'b10);
    lk_valid = 1'b0;

    // Fill to full under lookup load, refused push at full, order across wrap
    do_reset();
    exp_q.delete();
    got_q.delete();
    lk_valid = 1'b1;
    n = 0; c = 0;
    full_checked = 1'b0; pop_at_full = 1'b0; done = 1'b0;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
      if (upd === 1'b1) got_q.push_back(out_entry());
      if (lookup && upd) check("fill_both_strobes", {lookup, upd}, 2'b00);
      if (pop_at_full) begin
        check("fill_refused_at_full", count, 15);
        done = 1'b1;
        upd_valid = 1'b0;
      end else begin
        if (count == 5'd16 && !full_checked) begin
          check("fill_full_ready_low", upd_ready, 0);
          full_checked = 1'b1;
        end
        if (count == 5'd16 && !lk_ready) pop_at_full = 1'b1;
        if (upd_ready) begin
          e = mk_entry(100 + n);
          exp_q.push_back(e);
          set_upd(e);
          n++;
        end else begin
          set_upd('1);
        end
        upd_valid = 1'b1;
      end
    end
    check("fill_reached_pop_at_full", done, 1);
    lk_valid = 1'b0;
    upd_valid = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (upd === 1'b1) got_q.push_back(out_entry());
    end
    check("fill_drained", count, 0);
    check("fill_issue_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("fill_order%0d", i), got_q[i], exp_q[i]);

    // Burst limit 0: queued updates always go first
    do_reset();
    set_upd(mk_entry(200));
    upd_valid0 = 1'b1;
    lk_ip_addr = 32'h0C0C0C0C;
    @(negedge clk);
    set_upd(mk_entry(201));
    lk_valid0 = 1'b1;
    check("max0_lk_ready_low", lk_ready0, 0);
    @(negedge clk);
    check("max0_u0_strobes", {lookup0, upd0}, 2'b01);
    check("max0_u0_fields", out_entry0(), mk_entry(200));
    set_upd(mk_entry(202));
    @(negedge clk);
    upd_valid0 = 1'b0;
    check("max0_u1_strobes", {lookup0, upd0}, 2'b01);
    check("max0_u1_fields", out_entry0(), mk_entry(201));
    @(negedge clk);
    check("max0_u2_strobes", {lookup0, upd0}, 2'b01);
    check("max0_u2_fields", out_entry0(), mk_entry(202));
    @(negedge clk);
    check("max0_first_lookup", {lookup0, upd0}, 2'b10);
    check("max0_ready_back", lk_ready0, 1);
    lk_valid0 = 1'b0;

    // Asynchronous reset mid-burst with 5 queued
    do_reset();
    lk_valid = 1'b1;
    lk_ip_addr = 32'h55AA55AA;
    for (int j = 0; j < 5; j++) begin
      set_upd(mk_entry(300 + j));
      upd_valid = 1'b1;
      @(negedge clk);
    end
    upd_valid = 1'b0;
    check("mid_queued", count, 5);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_strobes", {lookup, upd}, 0);
    check("mid_rst_idle", idle, 1);
    check("mid_rst_readys", {lk_ready, upd_ready}, 0);
    @(negedge clk);
    rst = 1'b1;
    lk_valid = 1'b0;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (upd) stale++;
    end
    check("mid_no_stale_upd", stale, 0);
    check("mid_idle_after", idle, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sbp_lookup_sched.md
Name: sbp_lookup_sched

Overview:
- Request scheduler directly upstream of the pipelined lookup engine. It merges a lookup request stream and a buffered stream of table-update commands onto the engine's single shared lookup/update input slot.
- The engine gives lookups priority and silently drops a concurrent update. This block ensures no update is ever lost: updates are queued in a FIFO and issued only in slots without a lookup.
- A configurable burst limit guarantees that updates make forward progress under continuous lookup load.
- Reports when all queued updates have fully propagated through the engine's stages.

Parameters:
- STAGE_ID_BITS, 6, width of stage id fields
- LOCATION_BITS, 11, width of location fields
- UPD_FIFO_DEPTH, 16, update FIFO entries (power of two, >=2)
- MAX_LOOKUP_BURST, 8, max consecutive lookups issued while an update is pending; 0 = pending updates always win
- PIPE_LATENCY, 34, cycles from issue until the update is written in the last engine stage

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- lk_valid_i  in  1  lookup request valid
- lk_ready_o  out  1  lookup request accepted this cycle when high with lk_valid_i
- lk_ip_addr_i  in  32  address to look up
- upd_valid_i  in  1  update command valid
- upd_ready_o  out  1  update FIFO can accept
- upd_stage_id_i  in  STAGE_ID_BITS  target stage
- upd_location_i  in  LOCATION_BITS  target location
- upd_ip_addr_i  in  32  prefix to write
- upd_length_i  in  6  prefix length
- upd_childs_stage_id_i  in  STAGE_ID_BITS  child pointer stage
- upd_childs_location_i  in  LOCATION_BITS  child pointer location
- upd_childs_lr_i  in  2  child left/right flags
- lookup_o  out  1  to engine lookup_i
- ip_addr_o  out  32  to engine ip_addr_i
- upd_o  out  1  to engine upd_i
- upd_stage_id_o, upd_location_o, upd_ip_addr_o, upd_length_o, upd_childs_stage_id_o, upd_childs_location_o, upd_childs_lr_o  out  same widths as inputs  to engine update fields
- upd_count_o  out  $clog2(UPD_FIFO_DEPTH)+1  FIFO occupancy
- upd_idle_o  out  1  FIFO empty and no update in flight

Behaviour:
- Reset (rst low, async): FIFO empty, burst_cnt=0, inflight_cnt=0. All registered outputs are 0 except upd_idle_o=1. lk_ready_o=0 and upd_ready_o=0 while rst is low.
- FIFO:
  - 1 push per cycle, 74-bit packed entry.
  - upd_ready_o = (count < UPD_FIFO_DEPTH), from registered count only. A pop in the same cycle does not free space, so a full FIFO refuses a push even while popping.
  - A pushed entry becomes eligible for issue the cycle after the push (no fall-through).
  - Read/write pointers wrap modulo UPD_FIFO_DEPTH.
- Force rule:
  - force_upd = (count != 0) && (burst_cnt >= MAX_LOOKUP_BURST).
  - lk_ready_o = rst && !force_upd (combinational from registered state).
- Issue, one decision per cycle; outputs registered, latency 1 cycle:
  - lk_valid_i && lk_ready_o: lookup_o<=1, ip_addr_o<=lk_ip_addr_i, upd_o<=0, all upd_*_o<=0.
  - Else if count != 0: pop; upd_o<=1, lookup_o<=0, upd_*_o<=head fields, ip_addr_o<=0.
  - Else: all strobes and fields <=0.
  - lookup_o and upd_o are never both 1.
- burst_cnt:
  - Set to 0 when an update issues or when count==0.
  - Incremented (saturating at MAX_LOOKUP_BURST) when a lookup issues while count != 0.
- inflight_cnt:
  - Loaded with PIPE_LATENCY on each update issue.
  - Otherwise decrements to 0.
- upd_idle_o (registered) = (count==0) && (inflight_cnt==0), evaluated on next-state values.
- upd_count_o = registered count.
- Simultaneous push and pop: count unchanged; the popped entry is the older head.
- Reset mid-operation discards queued and in-flight bookkeeping immediately. Updates already inside the engine are not recalled.

Test Plan:
- Reset then idle -> lookup_o=upd_o=0, upd_idle_o=1, upd_ready_o=1, lk_ready_o=1 after rst rises.
- Single update push (stage 3, loc 5, ip 0x0A000000, len 8), no lookups -> upd_o=1 with those fields exactly 2 cycles after push. upd_idle_o falls, then returns to 1 exactly 34 cycles after the upd_o cycle.
- Continuous lk_valid_i with 1 queued update, MAX_LOOKUP_BURST=8 -> 8 lookups issue, lk_ready_o low for 1 cycle, update issues, then lookups resume. No cycle has both strobes high.
- Push 16 updates with lookups saturating -> upd_ready_o=0 at count=16. A push offered while popping at full is refused. All 16 later issue in FIFO order with fields intact across pointer wrap.
- MAX_LOOKUP_BURST=0 with 3 queued updates and lk_valid_i held -> 3 consecutive upd_o cycles before the first lookup_o.
- Assert rst mid-burst with 5 queued -> upd_count_o=0, strobes 0 asynchronously. After release, no stale update is issued.
